// File: rtl/reg_recovery_ctrl.sv
// reg_recovery_ctrl: on a branch mispredict, walks the register snapshot back
// into the register file one register per cycle, stalling the pipeline via busy.
//
// Ports:
//   clk, rst          - core clock, synchronous active-high reset
//   mispredict        - one-cycle restore request from hazard control
//   snapshot_valid    - snapshot holder done flag (contents stable while high)
//   regs_snapshot     - 32-entry snapshot register array
//   snapshot_ack      - one-cycle pulse clearing the snapshot done flag
//   rf_wr_en/addr/data- register-file restore write port
//   busy              - high while waiting for the snapshot or restoring
//   recovery_done     - one-cycle pulse after the last register is written
//   err_no_snapshot   - one-cycle pulse when the snapshot never arrived
module reg_recovery_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SKIP_R0    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mispredict,
  input  logic                  snapshot_valid,
  input  logic [DATA_WIDTH-1:0] regs_snapshot [32],
  output logic                  snapshot_ack,
  output logic                  rf_wr_en,
  output logic [4:0]            rf_wr_addr,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  output logic                  busy,
  output logic                  recovery_done,
  output logic                  err_no_snapshot
);

  localparam int unsigned AW = 5;
  localparam int unsigned TW = 4;
  localparam logic [AW-1:0] START_IDX = (SKIP_R0 != 0) ? AW'(1) : AW'(0);
  localparam logic [AW-1:0] LAST_IDX  = AW'(31);
  // Counter value seen on the 15th consecutive WAIT_SNAP cycle.
  localparam logic [TW-1:0] TMO_LAST  = TW'(14);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_SNAP,
    S_RESTORE,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  ack_q, ack_d;
  logic                  wr_en_q, wr_en_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  // Next-state and next-output logic; outputs are registered from the next state.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    ack_d   = 1'b0;
    wr_en_d = 1'b0;
    addr_d  = '0;
    data_d  = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mispredict) begin
          if (snapshot_valid) begin
            state_d = S_RESTORE;
            idx_d   = START_IDX;
            wr_en_d = 1'b1;
          end else begin
            state_d = S_WAIT_SNAP;
            tmo_d   = '0;
          end
        end
      end
      S_WAIT_SNAP: begin
        if (snapshot_valid) begin
          state_d = S_RESTORE;
          idx_d   = START_IDX;
          wr_en_d = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_IDLE;
          tmo_d   = '0;
          err_d   = 1'b1;
        end else begin
          tmo_d = TW'(tmo_q + TW'(1));
        end
      end
      S_RESTORE: begin
        // idx_q is the register written this cycle; stop after r31.
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
          idx_d   = START_IDX;
          ack_d   = 1'b1;
          done_d  = 1'b1;
        end else begin
          idx_d   = AW'(idx_q + AW'(1));
          wr_en_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (wr_en_d) begin
      addr_d = idx_d;
      data_d = regs_snapshot[idx_d];
    end
    busy_d = (state_d == S_WAIT_SNAP) || (state_d == S_RESTORE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= START_IDX;
      tmo_q   <= '0;
      ack_q   <= 1'b0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      ack_q   <= ack_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign snapshot_ack    = ack_q;
  assign rf_wr_en        = wr_en_q;
  assign rf_wr_addr      = addr_q;
  assign rf_wr_data      = data_q;
  assign busy            = busy_q;
  assign recovery_done   = done_q;
  assign err_no_snapshot = err_q;

  // The snapshot must remain valid for the whole walk; the walk itself carries on regardless.
  a_snapshot_held: assert property (@(posedge clk) disable iff (rst)
                                    (state_q == S_RESTORE) |-> snapshot_valid);

endmodule
